cache_tag_nway: RTL and testbench
=================================

Name: cache_tag_nway

Overview:
Parametrised N-way set-associative tag/state array with a tree pseudo-LRU, per-line valid and dirty bits, and a miss FSM.
The miss FSM sequences a dirty-victim write-back and a refill through ready/valid handshakes.
A flush walker sweeps every line and writes back dirty ones.
The block sits between the pipeline memory stage and the AXI bridge, and drives the data-array way select.

Parameters:
WAYS, 4, associativity; legal values 2, 4, 8.
INDEX_WD, 6, set index bits; sets = 2^INDEX_WD.
OFFSET_WD, 6, line offset bits; line = 2^OFFSET_WD bytes.
ADDR_WD, 32, address width; TAG_WD = ADDR_WD-INDEX_WD-OFFSET_WD.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  lookup request; held stable by the core while stallreq=1.
req_cached  in  1  1 = cacheable; 0 = no hit, no miss, no state change.
req_we  in  1  store request; sets dirty on hit or fill.
req_addr  in  ADDR_WD  request address.
flush_all  in  1  one-cycle pulse that starts a full write-back/invalidate sweep.
hit  out  WAYS  one-hot hit way, combinational.
miss  out  1  cacheable lookup missed in IDLE, combinational.
stallreq  out  1  miss | (state != IDLE).
way_sel  out  WAYS  one-hot way for the data array: the hit way in IDLE, the victim way otherwise.
wb_valid  out  1  write-back request.
wb_addr  out  ADDR_WD  {victim tag, index, OFFSET_WD zeros}.
wb_ready  in  1  write-back accepted and completed.
refill_valid  out  1  refill request.
refill_addr  out  ADDR_WD  {req tag, index, OFFSET_WD zeros}.
refill_done  in  1  refill data written into the data array.
flush_busy  out  1  flush sweep in progress.

Behaviour:
- Reset (async): all valid, dirty and PLRU bits = 0; state = IDLE; set/way counters = 0. All outputs are 0 while reset is high. Reset mid-operation abandons the transfer: wb_valid and refill_valid drop immediately, with no tag update.
- Lookup (IDLE only, combinational):
  - hit[w] = req_valid & req_cached & valid[idx][w] & (tag[idx][w] == req tag).
  - miss = req_valid & req_cached & ~|hit.
  - In any state other than IDLE, hit = 0 and miss = 0.
- Hit update (same edge): PLRU bits of idx point away from the hit way; if req_we, dirty[idx][hitway] = 1.
- Victim choice on miss: the lowest-numbered invalid way; if every way is valid, the way selected by the PLRU tree.
  - On the miss edge, capture address, we, idx and victim into registers.
- Miss FSM:
  - IDLE -> WB when victim valid & dirty; IDLE -> REFILL otherwise.
  - WB: wb_valid = 1, wb_addr from the stored victim tag. On wb_ready: clear dirty and valid of the victim, go to REFILL.
  - REFILL: refill_valid = 1. On refill_done: write tag; valid = 1; dirty = captured we; PLRU points away from the victim; go to IDLE.
  - The held request hits on the next cycle, so miss-to-hit latency = 2 + handshake wait cycles.
- Flush FSM:
  - flush_all is sampled in IDLE only and has priority over a same-cycle miss. Hit updates of that cycle are still applied.
  - FL_SCAN visits one (set, way) per cycle, way inner, set outer.
  - A valid & dirty line goes to FL_WB: wb_valid=1, wb_addr = line address. On wb_ready the line is cleared and the scan resumes at the next line.
  - A clean line is cleared in the scan cycle itself.
  - After the last set/way, go to IDLE; flush_busy falls on that transition.
  - flush_busy = state in {FL_SCAN, FL_WB}. flush_all arriving outside IDLE is ignored.
- Handshake rules:
  - wb_valid/refill_valid are held until their response input is seen high, and never assert together.
  - Response inputs seen while not in the matching state are ignored.
  - wb_ready and refill_done are single-cycle pulses.
- PLRU tree: WAYS-1 bits per set. Each bit: 0 = victim in the left (lower) half. Accessing way w flips the bits on its path to point away from w. For WAYS=2 this reduces to one bit.
- Uncached requests (req_cached=0) pass straight through: hit=0, miss=0, stallreq=0 in IDLE.

Test Plan:
- Cold miss, WAYS=4, addr 0x0000_1040 (idx 1, tag 0x1), refill_done 3 cycles later:
  - miss=1 and refill_addr=0x0000_1040 in the lookup cycle; refill_valid held 3 cycles.
  - Next IDLE cycle: hit=4'b0001.
- Store hit on 0x1040, then a fill of idx 1 with all 4 ways valid whose PLRU victim is way 0:
  - wb_valid=1, wb_addr=0x0000_1040; held until wb_ready (delay 5 cycles), then refill_valid.
- PLRU order: fill tags 1,2,3,4 into idx 1, touch tag 1, miss on tag 5 -> victim way_sel=4'b0100 (way 2).
- Flush with dirty lines at (idx 0, way 3) and (idx 63, way 1):
  - exactly two wb handshakes, addresses in scan order.
  - flush_busy high for 2^6*4 + write-back cycles.
  - afterwards every lookup misses.
- Reset asserted while wb_valid=1: wb_valid=0 asynchronously; after release, a lookup of the old address misses.
- Uncached req, addr 0x1040, after it is cached: hit=0, miss=0, stallreq=0, no PLRU/dirty change.

Source files
------------

// File: rtl/cache_tag_nway_if.sv
// rtl/cache_tag_nway_if.sv - lookup, write-back and refill bus of the set-associative tag array
interface cache_tag_nway_if #(
    parameter int WAYS    = 4,
    parameter int ADDR_WD = 32
);
    logic                req_valid;
    logic                req_cached;
    logic                req_we;
    logic [ADDR_WD-1:0]  req_addr;
    logic                flush_all;
    logic [WAYS-1:0]     hit;
    logic                miss;
    logic                stallreq;
    logic [WAYS-1:0]     way_sel;
    logic                wb_valid;
    logic [ADDR_WD-1:0]  wb_addr;
    logic                wb_ready;
    logic                refill_valid;
    logic [ADDR_WD-1:0]  refill_addr;
    logic                refill_done;
    logic                flush_busy;

    modport master (
        output req_valid, req_cached, req_we, req_addr, flush_all, wb_ready, refill_done,
        input  hit, miss, stallreq, way_sel, wb_valid, wb_addr, refill_valid, refill_addr,
               flush_busy
    );

    modport slave (
        input  req_valid, req_cached, req_we, req_addr, flush_all, wb_ready, refill_done,
        output hit, miss, stallreq, way_sel, wb_valid, wb_addr, refill_valid, refill_addr,
               flush_busy
    );
endinterface

// File: rtl/cache_tag_nway.sv
// rtl/cache_tag_nway.sv - N-way tag/state array with tree PLRU, miss FSM and flush walker
module cache_tag_nway #(
    parameter int WAYS      = 4,
    parameter int INDEX_WD  = 6,
    parameter int OFFSET_WD = 6,
    parameter int ADDR_WD   = 32
) (
    input  logic           clk,
    input  logic           reset,
    cache_tag_nway_if.slave bus
);
    localparam int TAG_WD = ADDR_WD - INDEX_WD - OFFSET_WD;
    localparam int SETS   = 1 << INDEX_WD;
    localparam int WAY_WD = $clog2(WAYS);

    localparam logic [WAY_WD-1:0]    WAY_ONE  = 1;
    localparam logic [WAY_WD-1:0]    WAY_LAST = WAY_WD'(WAYS - 1);
    localparam logic [INDEX_WD-1:0]  IDX_ONE  = 1;
    localparam logic [INDEX_WD-1:0]  IDX_LAST = INDEX_WD'(SETS - 1);
    localparam logic [OFFSET_WD-1:0] OFF_ZERO = '0;

    typedef enum logic [2:0] {IDLE, WB, REFILL, FL_SCAN, FL_WB} state_t;

    state_t              state;
    logic [TAG_WD-1:0]   tag_mem [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAYS-1:1]     plru_q  [SETS];

    logic [TAG_WD-1:0]   cap_tag;
    logic [INDEX_WD-1:0] cap_idx;
    logic                cap_we;
    logic [WAY_WD-1:0]   vic_q;
    logic [INDEX_WD-1:0] scan_set;
    logic [WAY_WD-1:0]   scan_way;
    logic                wb_valid_q;
    logic                refill_valid_q;
    logic                flush_busy_q;
    logic [ADDR_WD-1:0]  wb_addr_q;

    logic [TAG_WD-1:0]   req_tag;
    logic [INDEX_WD-1:0] req_idx;
    logic [WAYS-1:0]     hit_c;
    logic                miss_c;
    logic [WAY_WD-1:0]   hit_idx;
    logic [WAY_WD-1:0]   vic_c;
    logic                vic_found;
    logic [WAYS-1:0]     way_sel_c;
    logic                scan_last;
    logic                unused_offset;

    assign req_tag       = bus.req_addr[ADDR_WD-1 -: TAG_WD];
    assign req_idx       = bus.req_addr[OFFSET_WD +: INDEX_WD];
    assign unused_offset = ^bus.req_addr[OFFSET_WD-1:0];
    assign scan_last     = (scan_set == IDX_LAST) && (scan_way == WAY_LAST);

    // Heap-ordered tree: node n has children 2n (lower half) and 2n+1 (upper half).
    function automatic logic [WAYS-1:1] plru_touch(input logic [WAYS-1:1] bits,
                                                   input logic [WAY_WD-1:0] way);
        logic [WAY_WD-1:0] node;
        logic              d;
        node = WAY_ONE;
        for (int l = 0; l < WAY_WD; l++) begin
            d          = way[WAY_WD-1-l];
            bits[node] = ~d;
            node       = (node << 1) | WAY_WD'(d);
        end
        return bits;
    endfunction

    function automatic logic [WAY_WD-1:0] plru_victim(input logic [WAYS-1:1] bits);
        logic [WAY_WD-1:0] node;
        logic [WAY_WD-1:0] way;
        logic              d;
        node = WAY_ONE;
        way  = '0;
        for (int l = 0; l < WAY_WD; l++) begin
            d               = bits[node];
            way[WAY_WD-1-l] = d;
            node            = (node << 1) | WAY_WD'(d);
        end
        return way;
    endfunction

    always_comb begin
        hit_c   = '0;
        hit_idx = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_c[w] = bus.req_valid & bus.req_cached & valid_q[req_idx][w] &
                       (tag_mem[req_idx][w] == req_tag);
        end
        if (reset || state != IDLE) hit_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_c[w]) hit_idx = WAY_WD'(w);
        end
        miss_c = ~reset & (state == IDLE) & bus.req_valid & bus.req_cached & ~|hit_c;
    end

    // Prefer the lowest invalid way; the PLRU tree only decides when the set is full.
    always_comb begin
        vic_c     = plru_victim(plru_q[req_idx]);
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[req_idx][w]) begin
                vic_c     = WAY_WD'(w);
                vic_found = 1'b1;
            end
        end
    end

    // During a flush the data array must read the line being written back.
    always_comb begin
        way_sel_c = '0;
        case (state)
            IDLE:           way_sel_c = hit_c;
            FL_SCAN, FL_WB: way_sel_c[scan_way] = 1'b1;
            default:        way_sel_c[vic_q] = 1'b1;
        endcase
    end

    assign bus.hit          = hit_c;
    assign bus.miss         = miss_c;
    assign bus.stallreq     = miss_c | (state != IDLE);
    assign bus.way_sel      = way_sel_c;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_addr      = wb_addr_q;
    assign bus.refill_valid = refill_valid_q;
    assign bus.flush_busy   = flush_busy_q;
    assign bus.refill_addr  = reset ? '0 :
                              (state == IDLE) ? {req_tag, req_idx, OFF_ZERO}
                                              : {cap_tag, cap_idx, OFF_ZERO};

    always_ff @(posedge clk) begin
        if (state == REFILL && bus.refill_done) tag_mem[cap_idx][vic_q] <= cap_tag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            cap_tag        <= '0;
            cap_idx        <= '0;
            cap_we         <= 1'b0;
            vic_q          <= '0;
            scan_set       <= '0;
            scan_way       <= '0;
            wb_valid_q     <= 1'b0;
            refill_valid_q <= 1'b0;
            flush_busy_q   <= 1'b0;
            wb_addr_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|hit_c) begin
                        plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_idx);
                        if (bus.req_we) dirty_q[req_idx][hit_idx] <= 1'b1;
                    end
                    if (bus.flush_all) begin
                        state        <= FL_SCAN;
                        scan_set     <= '0;
                        scan_way     <= '0;
                        flush_busy_q <= 1'b1;
                    end else if (miss_c) begin
                        cap_tag <= req_tag;
                        cap_idx <= req_idx;
                        cap_we  <= bus.req_we;
                        vic_q   <= vic_c;
                        if (valid_q[req_idx][vic_c] && dirty_q[req_idx][vic_c]) begin
                            state      <= WB;
                            wb_valid_q <= 1'b1;
                            wb_addr_q  <= {tag_mem[req_idx][vic_c], req_idx, OFF_ZERO};
                        end else begin
                            state          <= REFILL;
                            refill_valid_q <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (bus.wb_ready) begin
                        valid_q[cap_idx][vic_q] <= 1'b0;
                        dirty_q[cap_idx][vic_q] <= 1'b0;
                        wb_valid_q              <= 1'b0;
                        refill_valid_q          <= 1'b1;
                        state                   <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.refill_done) begin
                        valid_q[cap_idx][vic_q] <= 1'b1;
                        dirty_q[cap_idx][vic_q] <= cap_we;
                        plru_q[cap_idx]         <= plru_touch(plru_q[cap_idx], vic_q);
                        refill_valid_q          <= 1'b0;
                        state                   <= IDLE;
                    end
                end
                FL_SCAN: begin
                    if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
                        state      <= FL_WB;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= {tag_mem[scan_set][scan_way], scan_set, OFF_ZERO};
                    end else begin
                        valid_q[scan_set][scan_way] <= 1'b0;
                        dirty_q[scan_set][scan_way] <= 1'b0;
                        scan_way <= scan_way + WAY_ONE;
                        if (scan_way == WAY_LAST) scan_set <= scan_set + IDX_ONE;
                        if (scan_last) begin
                            state        <= IDLE;
                            flush_busy_q <= 1'b0;
                        end
                    end
                end
                FL_WB: begin
                    if (bus.wb_ready) begin
                        valid_q[scan_set][scan_way] <= 1'b0;
                        dirty_q[scan_set][scan_way] <= 1'b0;
                        wb_valid_q <= 1'b0;
                        scan_way   <= scan_way + WAY_ONE;
                        if (scan_way == WAY_LAST) scan_set <= scan_set + IDX_ONE;
                        if (scan_last) begin
                            state        <= IDLE;
                            flush_busy_q <= 1'b0;
                        end else begin
                            state <= FL_SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_tag_nway.sv
// tb/tb_cache_tag_nway.sv - scoreboard bench for cache_tag_nway with directed vectors
module tb_cache_tag_nway;
    logic clk = 1'b0;
    logic reset;

    cache_tag_nway_if #(.WAYS(4), .ADDR_WD(32)) bus ();

    cache_tag_nway #(.WAYS(4), .INDEX_WD(6), .OFFSET_WD(6), .ADDR_WD(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [12:0] val;
        logic        chk_addr;
        logic [31:0] addr;
    } probe_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
    } xfer_t;

    probe_t probe_q[$];
    xfer_t  wb_q[$];
    xfer_t  rf_q[$];
    int     fb_q[$];

    logic  probe = 1'b0;
    logic  to_flag = 1'b0;
    string to_name = "";
    logic  done_req = 1'b0;
    logic  done_ack = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    fb_cnt = 0;

    probe_t      p;
    xfer_t       x;
    int          fb_exp;
    logic [12:0] act;

    function automatic logic [12:0] pv(input logic [3:0] h, input logic m, input logic s,
                                       input logic [3:0] ws, input logic wv, input logic rv,
                                       input logic fb);
        return {h, m, s, ws, wv, rv, fb};
    endfunction

    // Monitor: fields are {hit, miss, stallreq, way_sel, wb_valid, refill_valid, flush_busy}
    always @(negedge clk) begin
        act = {bus.hit, bus.miss, bus.stallreq, bus.way_sel, bus.wb_valid, bus.refill_valid,
               bus.flush_busy};
        if (probe) begin
            checks++;
            if (probe_q.size() == 0) begin
                errors++;
                $display("FAIL probe_underflow: no expectation queued");
            end else begin
                p = probe_q.pop_front();
                if (act !== p.val) begin
                    errors++;
                    $display("FAIL %s: got h/m/s/ws/wv/rv/fb=%b required %b", p.name, act, p.val);
                end
                if (p.chk_addr) begin
                    checks++;
                    if (bus.refill_addr !== p.addr) begin
                        errors++;
                        $display("FAIL %s_refill_addr: got %h required %h", p.name,
                                 bus.refill_addr, p.addr);
                    end
                end
            end
        end
        if (bus.wb_valid && bus.wb_ready) begin
            checks++;
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got addr %h required none", bus.wb_addr);
            end else begin
                x = wb_q.pop_front();
                if (bus.wb_addr !== x.addr) begin
                    errors++;
                    $display("FAIL %s: got wb_addr %h required %h", x.name, bus.wb_addr, x.addr);
                end
            end
        end
        if (bus.refill_valid && bus.refill_done) begin
            checks++;
            if (rf_q.size() == 0) begin
                errors++;
                $display("FAIL rf_unexpected: got addr %h required none", bus.refill_addr);
            end else begin
                x = rf_q.pop_front();
                if (bus.refill_addr !== x.addr) begin
                    errors++;
                    $display("FAIL %s: got refill_addr %h required %h", x.name,
                             bus.refill_addr, x.addr);
                end
            end
        end
        if (bus.flush_busy) begin
            fb_cnt++;
        end else if (fb_cnt > 0) begin
            checks++;
            if (fb_q.size() == 0) begin
                errors++;
                $display("FAIL flush_busy_unexpected: got %0d cycles required none", fb_cnt);
            end else begin
                fb_exp = fb_q.pop_front();
                if (fb_cnt != fb_exp) begin
                    errors++;
                    $display("FAIL flush_busy_len: got %0d cycles required %0d", fb_cnt, fb_exp);
                end
            end
            fb_cnt = 0;
        end
        if (to_flag) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout required event", to_name);
        end
        if (done_req && !done_ack) begin
            checks++;
            if (probe_q.size() + wb_q.size() + rf_q.size() + fb_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d pending expectations required 0",
                         probe_q.size() + wb_q.size() + rf_q.size() + fb_q.size());
            end
            done_ack = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chka(input string n, input logic [12:0] v, input logic ca,
                        input logic [31:0] a);
        probe_q.push_back('{n, v, ca, a});
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic chk(input string n, input logic [12:0] v);
        chka(n, v, 1'b0, 32'h0);
    endtask

    task automatic timeout(input string n);
        to_name = n;
        to_flag = 1'b1;
        @(negedge clk);
        #1;
        to_flag = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic we, input logic cached);
        bus.req_valid  = 1'b1;
        bus.req_cached = cached;
        bus.req_we     = we;
        bus.req_addr   = a;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    // Miss with a clean (or invalid) victim, immediate refill, then the held request hits.
    task automatic fill(input logic [31:0] a, input logic we, input logic [3:0] way);
        tick(); drive(a, we, 1'b1);
        rf_q.push_back('{"fill_refill_addr", a});
        chk("fill_miss", pv(4'b0, 1'b1, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0));
        tick(); bus.refill_done = 1'b1;
        chk("fill_refill", pv(4'b0, 1'b0, 1'b1, way, 1'b0, 1'b1, 1'b0));
        tick(); bus.refill_done = 1'b0;
        chk("fill_hit", pv(way, 1'b0, 1'b0, way, 1'b0, 1'b0, 1'b0));
        tick(); idle();
    endtask

    task automatic wait_wb(input int delay);
        int n;
        n = 0;
        while (!bus.wb_valid && n < 1000) begin
            tick();
            n++;
        end
        if (!bus.wb_valid) begin
            timeout("wb_valid_wait");
        end else begin
            repeat (delay) tick();
            bus.wb_ready = 1'b1;
            tick();
            bus.wb_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_cached  = 1'b1;
        bus.req_we      = 1'b0;
        bus.req_addr    = 32'h0000_1040;
        bus.flush_all   = 1'b0;
        bus.wb_ready    = 1'b0;
        bus.refill_done = 1'b0;

        tick();
        chka("reset_outputs", pv(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0), 1'b1, 32'h0);
        tick(); reset = 1'b0; idle();

        // Cold miss with refill_done three cycles after the lookup
        tick(); drive(32'h0000_1040, 1'b0, 1'b1);
        rf_q.push_back('{"cold_refill_addr", 32'h0000_1040});
        chka("cold_miss", pv(4'b0, 1'b1, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0), 1'b1, 32'h0000_1040);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) bus.refill_done = 1'b1;
            chk("cold_refill_hold", pv(4'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0));
        end
        tick(); bus.refill_done = 1'b0;
        chk("cold_hit", pv(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0));

        tick(); bus.req_we = 1'b1;
        chk("store_hit", pv(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0));
        tick(); idle();

        fill(32'h0000_2040, 1'b0, 4'b0010);
        fill(32'h0000_3040, 1'b0, 4'b0100);
        fill(32'h0000_4040, 1'b0, 4'b1000);

        // Full set, PLRU victim is dirty way 0: write-back held 5 cycles, then refill
        tick(); drive(32'h0000_5040, 1'b0, 1'b1);
        wb_q.push_back('{"evict_wb_addr", 32'h0000_1040});
        rf_q.push_back('{"evict_refill_addr", 32'h0000_5040});
        chk("evict_miss", pv(4'b0, 1'b1, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 4) bus.wb_ready = 1'b1;
            chk("evict_wb_hold", pv(4'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0));
        end
        tick(); bus.wb_ready = 1'b0; bus.refill_done = 1'b1;
        chk("evict_refill", pv(4'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0));
        tick(); bus.refill_done = 1'b0;
        chk("evict_hit", pv(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0));
        tick(); idle();

        // PLRU order in idx 2: tags 1..4, touch tag 1, tag 5 replaces way 2
        fill(32'h0000_1080, 1'b0, 4'b0001);
        fill(32'h0000_2080, 1'b0, 4'b0010);
        fill(32'h0000_3080, 1'b0, 4'b0100);
        fill(32'h0000_4080, 1'b0, 4'b1000);
        tick(); drive(32'h0000_1080, 1'b0, 1'b1);
        chk("plru_touch", pv(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0));
        fill(32'h0000_5080, 1'b0, 4'b0100);

        // Uncached store to a cached line: no hit, no stall, no dirty bit
        tick(); drive(32'h0000_1080, 1'b1, 1'b0);
        chk("uncached", pv(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0));
        tick(); drive(32'h0000_1080, 1'b0, 1'b1);
        chk("cached_after", pv(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0));
        tick(); idle();

        // Dirty lines at (idx 0, way 3) and (idx 63, way 1)
        fill(32'h0000_1000, 1'b0, 4'b0001);
        fill(32'h0000_2000, 1'b0, 4'b0010);
        fill(32'h0000_3000, 1'b0, 4'b0100);
        fill(32'h0000_4000, 1'b1, 4'b1000);
        fill(32'h0000_1FC0, 1'b0, 4'b0001);
        fill(32'h0000_2FC0, 1'b1, 4'b0010);

        tick(); bus.flush_all = 1'b1;
        wb_q.push_back('{"flush_wb0_addr", 32'h0000_4000});
        wb_q.push_back('{"flush_wb1_addr", 32'h0000_2FC0});
        fb_q.push_back(256 + 3 + 1);
        chk("flush_start", pv(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0));
        tick(); bus.flush_all = 1'b0;
        wait_wb(2);
        wait_wb(0);
        n = 0;
        while (bus.flush_busy && n < 1000) begin
            tick();
            n++;
        end
        if (bus.flush_busy) timeout("flush_done_wait");

        fill(32'h0000_2FC0, 1'b0, 4'b0001);
        fill(32'h0000_1080, 1'b0, 4'b0001);

        // Reset while a flush write-back is pending
        fill(32'h0000_1140, 1'b1, 4'b0001);
        tick(); bus.flush_all = 1'b1;
        fb_q.push_back(21);
        tick(); bus.flush_all = 1'b0;
        n = 0;
        while (!bus.wb_valid && n < 1000) begin
            tick();
            n++;
        end
        if (!bus.wb_valid) timeout("reset_wb_wait");
        #1 reset = 1'b1;
        chka("reset_mid_wb", pv(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0), 1'b1, 32'h0);
        tick(); tick(); reset = 1'b0;
        fill(32'h0000_1140, 1'b0, 4'b0001);

        tick(); done_req = 1'b1;
        n = 0;
        while (!done_ack && n < 10) begin
            tick();
            n++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
